// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default oversampling and parity mode.
// Also used by the transmitter so both ends agree on framing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_mode_t;

    localparam int           OVERSAMPLE_DEFAULT = 16;
    localparam parity_mode_t PARITY_MODE        = PARITY_EVEN;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous RxD line.
// Resets to 1 so the line reads idle-high while reset is applied.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_ff;

    // NOTE: resetting to the idle level keeps a reset release from looking like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start, DATA_BITS LSB-first, parity, stop.
// Optional macro RX_MAJORITY_VOTE_EN: 2-of-3 majority vote around each mid-bit sample point.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR
);

    localparam int MID    = OVERSAMPLE / 2 - 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    rx_state_t             state, next_state;
    logic [TICK_W-1:0]     tick_cnt, tick_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  rxd_s;
    logic                  bit_val;
    logic                  do_shift, do_parity, do_stop, clr_flags;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (RxD),
        .q    (rxd_s)
    );

`ifdef RX_MAJORITY_VOTE_EN
    // Deciding one tick late lets the vote see samples n-1, n and n+1; later points follow.
    localparam logic [TICK_W-1:0] START_PT = TICK_W'(MID + 1);

    logic [1:0] hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '1;
        end else if (sample_tick) begin
            hist <= {hist[0], rxd_s};
        end
    end

    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
    localparam logic [TICK_W-1:0] START_PT = TICK_W'(MID);

    assign bit_val = rxd_s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        tick_nxt   = tick_cnt;
        bit_nxt    = bit_cnt;
        do_shift   = 1'b0;
        do_parity  = 1'b0;
        do_stop    = 1'b0;
        clr_flags  = 1'b0;

        if (!Rx_EN) begin
            next_state = IDLE;
            tick_nxt   = '0;
            bit_nxt    = '0;
        end else if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        next_state = START;
                        tick_nxt   = '0;
                    end
                end
                START: begin
                    if (tick_cnt == START_PT) begin
                        tick_nxt = '0;
                        if (bit_val) begin
                            next_state = IDLE;
                        end else begin
                            next_state = DATA;
                            bit_nxt    = '0;
                            clr_flags  = 1'b1;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_nxt = '0;
                        do_shift = 1'b1;
                        bit_nxt  = bit_cnt + BIT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            next_state = PARITY;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TICK_W'(1);
                    end
                end
                PARITY: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_nxt   = '0;
                        do_parity  = 1'b1;
                        next_state = STOP;
                    end else begin
                        tick_nxt = tick_cnt + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_nxt   = '0;
                        do_stop    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        tick_nxt = tick_cnt + TICK_W'(1);
                    end
                end
                default: begin
                    next_state = IDLE;
                    tick_nxt   = '0;
                    bit_nxt    = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            Rx_VALID <= do_stop;
            if (do_shift) begin
                shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
            end
            if (clr_flags) begin
                Rx_PERROR <= 1'b0;
                Rx_FERROR <= 1'b0;
            end
            if (do_parity) begin
                Rx_PERROR <= (^{shift_reg, bit_val}) != PARITY_MODE;
            end
            // Data is delivered even when the stop bit is bad; the flag reports it.
            if (do_stop) begin
                Rx_FERROR <= ~bit_val;
                Rx_DATA   <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of frames plus hand-built corner sequences.
// Honours RX_MAJORITY_VOTE_EN when it is defined for the build.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    int         errors = 0;
    int         checks = 0;
    logic       tick_en = 1'b1;
    logic [1:0] div = '0;
    logic [7:0] vq[$];

`ifdef RX_MAJORITY_VOTE_EN
    localparam int STOP_PT = 10;
`else
    localparam int STOP_PT = 9;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[6];

    uart_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .Rx_EN      (Rx_EN),
        .RxD        (RxD),
        .Rx_DATA    (Rx_DATA),
        .Rx_VALID   (Rx_VALID),
        .Rx_PERROR  (Rx_PERROR),
        .Rx_FERROR  (Rx_FERROR)
    );

    always #5 clk = ~clk;

    // One sample tick every fourth clock, changed on the falling edge.
    initial begin
        sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            div         = div + 2'd1;
            sample_tick = tick_en && (div == 2'd3);
        end
    end

    always @(negedge clk) begin
        if (Rx_VALID) vq.push_back(Rx_DATA);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!sample_tick) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        @(negedge clk);
        RxD = v;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
        send_bit(par, 16);
        send_bit(stop, 16);
    endtask

    task automatic idle(input int n);
        send_bit(1'b1, n);
    endtask

    initial begin
        int n0;
        logic [7:0] d;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[3] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0};

        reset = 1'b1;
        Rx_EN = 1'b1;
        RxD   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_data", Rx_DATA, 8'h00);
        check("reset_valid", Rx_VALID, 1'b0);
        check("reset_perror", Rx_PERROR, 1'b0);
        check("reset_ferror", Rx_FERROR, 1'b0);
        idle(8);

        for (int v = 0; v < 6; v++) begin
            n0 = vq.size();
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
            idle(24);
            check($sformatf("vec%0d_valid_count", v), vq.size() - n0, 1);
            check($sformatf("vec%0d_data", v), Rx_DATA, vecs[v].exp_data);
            check($sformatf("vec%0d_perror", v), Rx_PERROR, vecs[v].exp_pe);
            check($sformatf("vec%0d_ferror", v), Rx_FERROR, vecs[v].exp_fe);
        end

        // Short low pulse on an idle line is a glitch, not a start bit.
        n0 = vq.size();
        send_bit(1'b0, 4);
        idle(24);
        check("glitch_no_valid", vq.size() - n0, 0);
        check("glitch_data_held", Rx_DATA, 8'h7E);

        // Disable after three data bits of 0x55, then finish the frame on the wire.
        n0 = vq.size();
        d  = 8'h55;
        send_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(d[i], 16);
        Rx_EN = 1'b0;
        for (int i = 3; i < 8; i++) send_bit(d[i], 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        idle(24);
        check("disable_no_valid", vq.size() - n0, 0);
        check("disable_data_held", Rx_DATA, 8'h7E);
        @(negedge clk);
        Rx_EN = 1'b1;
        idle(8);
        n0 = vq.size();
        send_frame(8'h55, 1'b0, 1'b1);
        idle(24);
        check("reenable_valid_count", vq.size() - n0, 1);
        check("reenable_data", Rx_DATA, 8'h55);
        check("reenable_perror", Rx_PERROR, 1'b0);

        // Back-to-back frames with no idle gap.
        n0 = vq.size();
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1);
        idle(24);
        check("b2b_valid_count", vq.size() - n0, 2);
        if (vq.size() >= n0 + 2) begin
            check("b2b_first", vq[n0], 8'h12);
            check("b2b_second", vq[n0+1], 8'h34);
        end

        // Ticks paused mid-bit: counters must freeze and resume.
        n0 = vq.size();
        d  = 8'hC3;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(d[i], 16);
        send_bit(d[4], 8);
        tick_en = 1'b0;
        repeat (60) @(posedge clk);
        tick_en = 1'b1;
        wait_ticks(8);
        for (int i = 5; i < 8; i++) send_bit(d[i], 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        idle(24);
        check("freeze_valid_count", vq.size() - n0, 1);
        check("freeze_data", Rx_DATA, 8'hC3);

        // Rx_VALID lands one clock after the stop-bit decision tick, for one clock.
        d = 8'h96;
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, STOP_PT - 1);
        check("latency_before", Rx_VALID, 1'b0);
        wait_ticks(1);
        #1;
        check("latency_valid", Rx_VALID, 1'b1);
        check("latency_data", Rx_DATA, 8'h96);
        @(posedge clk);
        #1;
        check("latency_single_cycle", Rx_VALID, 1'b0);
        wait_ticks(16 - STOP_PT);
        idle(24);

`ifdef RX_MAJORITY_VOTE_EN
        // One-tick low glitch at the mid point of a 1 data bit is outvoted.
        n0 = vq.size();
        send_bit(1'b0, 16);
        send_bit(1'b1, 8);
        send_bit(1'b0, 1);
        send_bit(1'b1, 7);
        for (int i = 1; i < 8; i++) send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        idle(24);
        check("vote_valid_count", vq.size() - n0, 1);
        check("vote_data", Rx_DATA, 8'hFF);
        check("vote_perror", Rx_PERROR, 1'b0);
`endif

        // Asynchronous reset mid-frame: outputs clear at once and the frame is lost.
        n0 = vq.size();
        d  = 8'hE7;
        send_bit(1'b0, 16);
        send_bit(d[0], 16);
        send_bit(d[1], 8);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_data", Rx_DATA, 8'h00);
        check("midreset_valid", Rx_VALID, 1'b0);
        check("midreset_perror", Rx_PERROR, 1'b0);
        check("midreset_ferror", Rx_FERROR, 1'b0);
        RxD = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(40);
        check("midreset_no_valid", vq.size() - n0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
